serial_subtractor: RTL

Bit-serial unsigned subtractor that computes `diff = a - b` one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. It is the subtraction counterpart of the adder blocks in the arithmetic library. It sits between a requester that presents two operands with a `start` pulse and a consumer that samples the result on `done`.

---
 rtl/arith_pkg.sv | 15 +
 rtl/full_subtractor.sv | 16 +
 rtl/serial_subtractor.sv | 90 +++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter width able to index every bit position of a WIDTH-bit operand
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference and borrow-out for one bit position
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int unsigned   CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow_q;
  logic             d_c;
  logic             bout_c;

  full_subtractor u_cell (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (borrow_q),
    .d    (d_c),
    .bout (bout_c)
  );

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with registered status flags decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  // Operand/result shift registers, borrow flop and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else if (state == IDLE && start) begin
      a_sr     <= a;
      b_sr     <= b;
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else if (state == RUN) begin
      a_sr     <= a_sr >> 1;
      b_sr     <= b_sr >> 1;
      res_sr   <= {d_c, res_sr[WIDTH-1:1]};
      borrow_q <= bout_c;
      // Hold on the last bit so the counter never wraps
      if (cnt != LAST) cnt <= cnt + CW'(1);
    end
  end

  // Result is exposed straight from the result register and borrow flop
  assign diff   = res_sr;
  assign borrow = borrow_q;

endmodule
